// File: rtl/seq_pkg.sv
// Shared definitions for the 3-bit NOR/XOR sequence link: checker FSM states,
// word width and the next-word function used by both generator and checker.
package seq_pkg;

  localparam int SEQ_W = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } seq_state_t;

  // Successor of x in the period-8 sequence 0,4,2,5,6,7,3,1
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] x);
    logic d;
    d = (x[1] ^ x[0]) ^ ~(x[2] | x[1]);
    return {d, x[2], x[1]};
  endfunction

endpackage

// File: rtl/seq_next_calc.sv
// Combinational next-word predictor for the 3-bit sequence; shared with the
// generator side of the link.
module seq_next_calc
  import seq_pkg::*;
(
  input  logic [SEQ_W-1:0] i_x,
  output logic [SEQ_W-1:0] o_next
);

  assign o_next = seq_next(i_x);

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker for the 3-bit sequence: hunts for the sequence, verifies
// LOCK_CNT consecutive matches, then flywheels and counts errors while locked.
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             in_valid,
  input  logic [SEQ_W-1:0] in_x,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [SEQ_W-1:0] expected
);

  localparam int CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CNT - 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  seq_state_t       r_state,    w_state;
  logic [CNT_W-1:0] r_good_cnt, w_good_cnt;
  logic [CNT_W-1:0] r_bad_cnt,  w_bad_cnt;
  logic [SEQ_W-1:0] r_expected, w_expected;
  logic             r_locked;
  logic             r_err_pulse, w_err_pulse;
  logic [ERR_W-1:0] r_err_count;
  logic             w_err_inc;
  logic [SEQ_W-1:0] w_next_in;
  logic [SEQ_W-1:0] w_next_exp;
  logic             w_match;

  seq_next_calc u_next_in  (.i_x(in_x),       .o_next(w_next_in));
  seq_next_calc u_next_exp (.i_x(r_expected), .o_next(w_next_exp));

  assign w_match = (in_x == r_expected);

  always_comb begin
    w_state     = r_state;
    w_good_cnt  = r_good_cnt;
    w_bad_cnt   = r_bad_cnt;
    w_expected  = r_expected;
    w_err_pulse = 1'b0;
    w_err_inc   = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        HUNT: begin
          w_expected = w_next_in;
          w_good_cnt = '0;
          w_state    = VERIFY;
        end
        VERIFY: begin
          // Reseed from the received word on both outcomes; only matches advance
          w_expected = w_next_in;
          if (w_match) begin
            w_good_cnt = r_good_cnt + CNT_W'(1);
            if (r_good_cnt == LOCK_LAST) begin
              w_state   = LOCKED;
              w_bad_cnt = '0;
            end
          end else begin
            w_good_cnt = '0;
          end
        end
        LOCKED: begin
          // Flywheel: a corrupt sample must not derail the prediction
          w_expected = w_next_exp;
          if (w_match) begin
            w_bad_cnt = '0;
          end else begin
            w_err_pulse = 1'b1;
            w_err_inc   = 1'b1;
            w_bad_cnt   = r_bad_cnt + CNT_W'(1);
            if (r_bad_cnt == LOSS_LAST) w_state = HUNT;
          end
        end
        default: w_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_state    <= HUNT;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state;
      r_good_cnt <= w_good_cnt;
      r_bad_cnt  <= w_bad_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_expected  <= '0;
    end else begin
      r_locked    <= (w_state == LOCKED);
      r_err_pulse <= w_err_pulse;
      r_expected  <= w_expected;
      if (clr_cnt)        r_err_count <= '0;
      else if (w_err_inc) r_err_count <= sat_inc(r_err_count);
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: default build, a narrow saturating counter
// build with a long loss window, and a LOCK_CNT=LOSS_CNT=1 build.
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_x = 3'd0;
  logic       clr_cnt = 1'b0;

  logic       locked1, pulse1;
  logic [7:0] cnt1;
  logic [2:0] exp1;
  logic       locked2, pulse2;
  logic [1:0] cnt2;
  logic [2:0] exp2;
  logic       locked3, pulse3;
  logic [7:0] cnt3;
  logic [2:0] exp3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) u_dut1 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_x(in_x), .clr_cnt(clr_cnt),
    .locked(locked1), .err_pulse(pulse1), .err_count(cnt1), .expected(exp1)
  );

  seq_checker #(.LOCK_CNT(4), .LOSS_CNT(16), .ERR_W(2)) u_dut2 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_x(in_x), .clr_cnt(clr_cnt),
    .locked(locked2), .err_pulse(pulse2), .err_count(cnt2), .expected(exp2)
  );

  seq_checker #(.LOCK_CNT(1), .LOSS_CNT(1), .ERR_W(8)) u_dut3 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_x(in_x), .clr_cnt(clr_cnt),
    .locked(locked3), .err_pulse(pulse3), .err_count(cnt3), .expected(exp3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] x, input logic clr);
    @(negedge clk);
    aclr = 1'b0; in_valid = 1'b1; in_x = x; clr_cnt = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    aclr = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic v, input logic [2:0] x);
    @(negedge clk);
    aclr = 1'b1; in_valid = v; in_x = x; clr_cnt = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk1(input string tag, input logic l, input logic p,
                      input logic [7:0] c, input logic [2:0] e);
    check({tag, "_locked"}, 32'(locked1), 32'(l));
    check({tag, "_pulse"},  32'(pulse1),  32'(p));
    check({tag, "_count"},  32'(cnt1),    32'(c));
    check({tag, "_exp"},    32'(exp1),    32'(e));
  endtask

  initial begin
    // reset state
    do_reset(1'b0, 3'd0);
    chk1("rst", 0, 0, 0, 0);
    check("rst_cnt2", 32'(cnt2), 0);
    check("rst_lock3", 32'(locked3), 0);

    // 1: acquire lock
    send(3'd0, 0); chk1("t1_s0", 0, 0, 0, 4);
    send(3'd4, 0); chk1("t1_s4", 0, 0, 0, 2);
    check("t1_lock3_early", 32'(locked3), 1);
    send(3'd2, 0); chk1("t1_s2", 0, 0, 0, 5);
    send(3'd5, 0); chk1("t1_s5", 0, 0, 0, 6);
    send(3'd6, 0); chk1("t1_s6", 1, 0, 0, 7);

    // 2: single corrupt word, flywheel keeps tracking
    send(3'd3, 0); chk1("t2_e", 1, 1, 1, 3);
    check("t2_lock3_lost", 32'(locked3), 0);
    check("t2_pulse3", 32'(pulse3), 1);
    send(3'd3, 0); chk1("t2_a", 1, 0, 1, 1);
    send(3'd1, 0); chk1("t2_b", 1, 0, 1, 0);
    send(3'd0, 0); chk1("t2_c", 1, 0, 1, 4);

    // 3: three consecutive errors drop lock, then relock
    send(3'd4, 0); send(3'd2, 0); send(3'd5, 0);
    send(3'd6, 0); chk1("t3_pre", 1, 0, 1, 7);
    send(3'd5, 0); chk1("t3_e1", 1, 1, 2, 3);
    send(3'd5, 0); chk1("t3_e2", 1, 1, 3, 1);
    send(3'd5, 0); chk1("t3_e3", 0, 1, 4, 0);
    send(3'd0, 0); chk1("t3_r0", 0, 0, 4, 4);
    send(3'd4, 0); send(3'd2, 0);
    send(3'd5, 0); chk1("t3_r5", 0, 0, 4, 6);
    send(3'd6, 0); chk1("t3_r6", 1, 0, 4, 7);

    // 4: gapped stream after reset
    do_reset(1'b0, 3'd0);
    chk1("t4_rst", 0, 0, 0, 0);
    send(3'd0, 0); idle(); chk1("t4_i0", 0, 0, 0, 4);
    send(3'd4, 0); idle(); chk1("t4_i4", 0, 0, 0, 2);
    send(3'd2, 0); idle(); chk1("t4_i2", 0, 0, 0, 5);
    send(3'd5, 0); idle(); chk1("t4_i5", 0, 0, 0, 6);
    send(3'd6, 0); chk1("t4_s6", 1, 0, 0, 7);
    idle(); chk1("t4_i6", 1, 0, 0, 7);

    // 5: saturation of the 2-bit counter and clr_cnt priority
    check("t5_lock2", 32'(locked2), 1);
    send(3'd0, 0); check("t5_c1", 32'(cnt2), 1);
    send(3'd3, 0);
    send(3'd0, 0); check("t5_c2", 32'(cnt2), 2);
    send(3'd0, 0);
    send(3'd0, 0); check("t5_c3", 32'(cnt2), 3);
    send(3'd2, 0);
    send(3'd0, 0); check("t5_sat", 32'(cnt2), 3);
    check("t5_exp2", 32'(exp2), 6);
    send(3'd6, 0);
    send(3'd0, 1);
    check("t5_clr_cnt", 32'(cnt2), 0);
    check("t5_clr_pulse", 32'(pulse2), 1);
    check("t5_still_locked2", 32'(locked2), 1);
    chk1("t5_d1", 1, 1, 0, 3);

    // 6: reset while locked with errors, then VERIFY reseed
    send(3'd0, 0); send(3'd1, 0);
    send(3'd1, 0); chk1("t6_pre", 1, 1, 2, 4);
    do_reset(1'b1, 3'd5);
    chk1("t6_rst", 0, 0, 0, 0);
    send(3'd0, 0); chk1("t6_h", 0, 0, 0, 4);
    send(3'd5, 0); chk1("t6_reseed", 0, 0, 0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
